// File: rtl/cm3_adc.sv
// cm3_adc: AHB-Lite slave ADC peripheral.
// The 1-bit comparator decision (vp & ~vn) is counted over a window of DIV+1
// cycles. Each window produces one 16-bit saturated sample. In pair mode two
// consecutive samples are packed into one 32-bit DATA word.
//
// Ports:
//   hclk, rst_n     clock, asynchronous active-low reset
//   hsel, hready_i, hwrite, htrans, haddr, hwdata
//                   AHB-Lite address/data phase inputs (only haddr[3:2] decoded)
//   hrdata          read data, combinational from the latched address
//   hready_o, hresp fixed 1 / 0 (zero wait states, always OKAY)
//   vp, vn          comparator inputs
//   int_o           level interrupt, VALID & IE ("int" is a reserved word)
//
// Register map: 0x0 CTRL {DBL,IE,EN}, 0x4 DIV[15:0], 0x8 DATA (RO, read
// clears VALID), 0xC STAT {OVR (W1C), VALID}.
module cm3_adc #(
  parameter logic [15:0] DIV_RST = 16'h0C34
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic        hready_i,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready_o,
  output logic        hresp,
  input  logic        vp,
  input  logic        vn,
  output logic        int_o
);

  function automatic logic [15:0] sat16(input logic [16:0] v);
    sat16 = v[16] ? 16'hFFFF : v[15:0];
  endfunction

  // Bus phase state
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  addr_q, addr_d;

  // Registers
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        dbl_q, dbl_d;
  logic [15:0] div_q, div_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        ovr_q, ovr_d;

  // Sampling state
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] acc_q, acc_d;
  logic        half_q, half_d;
  logic [15:0] first_q, first_d;

  // Combinational helpers
  logic        addr_ok;
  logic        wr_ctrl, wr_div, wr_stat, data_rd;
  logic        bit_in, restart, fire, upd;
  logic [16:0] acc_sum;
  logic [15:0] sample;
  logic [31:0] upd_data;

  logic unused_bits;
  assign unused_bits = ^{haddr[31:4], haddr[1:0], hwdata[31:16], htrans[0]};

  always_comb begin
    addr_ok = hsel & hready_i & htrans[1];
    wr_d    = addr_ok & hwrite;
    rd_d    = addr_ok & ~hwrite;
    addr_d  = addr_ok ? haddr[3:2] : addr_q;

    wr_ctrl = wr_q & (addr_q == 2'd0);
    wr_div  = wr_q & (addr_q == 2'd1);
    wr_stat = wr_q & (addr_q == 2'd3);
    data_rd = rd_q & (addr_q == 2'd2);

    en_d  = wr_ctrl ? hwdata[0] : en_q;
    ie_d  = wr_ctrl ? hwdata[1] : ie_q;
    dbl_d = wr_ctrl ? hwdata[2] : dbl_q;
    div_d = wr_div ? hwdata[15:0] : div_q;

    // Window counter / accumulator. The accumulator never exceeds 0xFFFF,
    // so a 17-bit add of one bit cannot wrap before saturation.
    bit_in  = vp & ~vn;
    acc_sum = acc_q + {16'h0000, bit_in};
    sample  = sat16(acc_sum);
    restart = ~en_q | wr_div;
    fire    = en_q & ~wr_div & (cnt_q == div_q);

    cnt_d = cnt_q + 16'd1;
    acc_d = {1'b0, sample};
    if (restart || fire) begin
      cnt_d = 16'd0;
      acc_d = 17'd0;
    end

    // Pair packing: first sample of a pair is parked in first_q.
    half_d   = half_q;
    first_d  = first_q;
    upd      = 1'b0;
    upd_data = {16'h0000, sample};
    if (fire) begin
      if (dbl_q) begin
        if (half_q) begin
          upd      = 1'b1;
          upd_data = {sample, first_q};
          half_d   = 1'b0;
        end else begin
          first_d = sample;
          half_d  = 1'b1;
        end
      end else begin
        upd = 1'b1;
      end
    end
    if (restart || (wr_ctrl && (hwdata[2] != dbl_q))) begin
      half_d = 1'b0;
    end

    // DATA / VALID / OVR. An update beats a same-cycle DATA read: VALID stays
    // set and the read does not count as an overrun.
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (wr_stat && hwdata[1]) begin
      ovr_d = 1'b0;
    end
    if (upd) begin
      data_d  = upd_data;
      valid_d = 1'b1;
      if (valid_q && !data_rd) begin
        ovr_d = 1'b1;
      end
    end else if (data_rd) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    hrdata = 32'h0000_0000;
    if (rd_q) begin
      case (addr_q)
        2'd0:    hrdata = {29'h0, dbl_q, ie_q, en_q};
        2'd1:    hrdata = {16'h0000, div_q};
        2'd2:    hrdata = data_q;
        default: hrdata = {30'h0, ovr_q, valid_q};
      endcase
    end
  end

  assign hready_o = 1'b1;
  assign hresp    = 1'b0;
  assign int_o    = valid_q & ie_q;

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 2'd0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      dbl_q   <= 1'b0;
      div_q   <= DIV_RST;
      data_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= 16'd0;
      acc_q   <= 17'd0;
      half_q  <= 1'b0;
      first_q <= 16'd0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      dbl_q   <= dbl_d;
      div_q   <= div_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      half_q  <= half_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_cm3_adc.sv
// Bench for cm3_adc: directed AHB transfers; expected read data is queued at
// issue time and compared by a monitor when the read data phase is presented.
module tb_cm3_adc;

  logic        hclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic        hready_i = 1'b1;
  logic        hwrite = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [31:0] hwdata = 32'h0;
  logic [31:0] hrdata;
  logic        hready_o;
  logic        hresp;
  logic        vp = 1'b0;
  logic        vn = 1'b0;
  logic        int_o;

  cm3_adc dut (
    .hclk(hclk), .rst_n(rst_n), .hsel(hsel), .hready_i(hready_i),
    .hwrite(hwrite), .htrans(htrans), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .hready_o(hready_o), .hresp(hresp),
    .vp(vp), .vn(vn), .int_o(int_o)
  );

  always #5 hclk = ~hclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_dp = 1'b0;
  logic [31:0] mon_e;
  string       mon_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: read data phase is sampled mid-cycle.
  always @(negedge hclk) begin
    if (rd_dp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected none", hrdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk(mon_n, hrdata, mon_e);
      end
    end
  end

  // Returns 1ns after the edge at which the write takes effect.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    @(posedge hclk); #1;
  endtask

  // Returns 1ns after the edge that ends the read data phase.
  task automatic ahb_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = addr;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    rd_dp = 1'b1;
    @(posedge hclk); #1;
    rd_dp = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_int", {31'h0, int_o}, 32'h0);
    chk("rst_hready", {31'h0, hready_o}, 32'h1);
    chk("rst_hresp", {31'h0, hresp}, 32'h0);
    rst_n = 1'b1;
    ahb_read(32'h0, 32'h0, "rst_ctrl");
    ahb_read(32'h4, 32'h0000_0C34, "rst_div");
    ahb_read(32'h8, 32'h0, "rst_data");
    ahb_read(32'hC, 32'h0, "rst_stat");

    // Default-length pair window, comparator idle
    vp = 1'b0; vn = 1'b0;
    ahb_write(32'h0, 32'h7);
    ahb_write(32'h4, 32'hC34);
    repeat (6249) @(posedge hclk);
    #1 chk("c34_int_early", {31'h0, int_o}, 32'h0);
    @(posedge hclk);
    #1 chk("c34_int_rise", {31'h0, int_o}, 32'h1);
    ahb_read(32'h8, 32'h0, "c34_data");
    chk("c34_int_drop", {31'h0, int_o}, 32'h0);
    ahb_write(32'h0, 32'h0);

    // Comparator active, short window, single then pair mode
    vp = 1'b1; vn = 1'b0;
    ahb_write(32'h4, 32'd9);
    ahb_write(32'h0, 32'h3);
    repeat (9) @(posedge hclk);
    #1 chk("single_int_early", {31'h0, int_o}, 32'h0);
    @(posedge hclk);
    #1 chk("single_int_rise", {31'h0, int_o}, 32'h1);
    ahb_read(32'h8, 32'h0000_000A, "single_data");
    ahb_write(32'h0, 32'h0);
    ahb_write(32'h0, 32'h7);
    repeat (19) @(posedge hclk);
    #1 chk("pair_int_early", {31'h0, int_o}, 32'h0);
    @(posedge hclk);
    #1 chk("pair_int_rise", {31'h0, int_o}, 32'h1);
    ahb_read(32'h8, 32'h000A_000A, "pair_data");
    ahb_write(32'h0, 32'h0);

    // Both comparator inputs high: no counts
    vp = 1'b1; vn = 1'b1;
    ahb_write(32'h0, 32'h3);
    repeat (10) @(posedge hclk);
    #1 chk("inactive_int", {31'h0, int_o}, 32'h1);
    ahb_read(32'h8, 32'h0, "inactive_data");
    ahb_write(32'h0, 32'h0);

    // Saturation over the longest window
    vp = 1'b1; vn = 1'b0;
    ahb_write(32'h4, 32'hFFFF);
    ahb_write(32'h0, 32'h3);
    repeat (65535) @(posedge hclk);
    #1 chk("sat_int_early", {31'h0, int_o}, 32'h0);
    @(posedge hclk);
    #1 chk("sat_int_rise", {31'h0, int_o}, 32'h1);
    ahb_read(32'h8, 32'h0000_FFFF, "sat_data");
    ahb_write(32'h0, 32'h0);

    // Overrun and OVR write-1-to-clear
    ahb_write(32'h4, 32'd3);
    ahb_write(32'h0, 32'h1);
    repeat (12) @(posedge hclk);
    ahb_read(32'hC, 32'h3, "ovr_stat");
    ahb_write(32'h0, 32'h0);
    ahb_write(32'hC, 32'h2);
    ahb_read(32'hC, 32'h1, "ovr_cleared");
    ahb_read(32'h8, 32'h4, "ovr_data");
    ahb_read(32'hC, 32'h0, "ovr_valid_cleared");

    // DATA read coinciding with a DATA update (window of 4, updates at +4, +8)
    ahb_write(32'h0, 32'h1);
    repeat (5) @(posedge hclk);
    ahb_read(32'h8, 32'h4, "coll_data");
    ahb_write(32'h0, 32'h0);
    ahb_read(32'hC, 32'h1, "coll_stat");
    ahb_read(32'h8, 32'h4, "coll_data2");

    // Reset in the middle of a window
    ahb_write(32'h4, 32'd9);
    ahb_write(32'h0, 32'h3);
    repeat (5) @(posedge hclk);
    @(negedge hclk);
    rst_n = 1'b0;
    @(posedge hclk);
    #1;
    chk("mid_rst_int", {31'h0, int_o}, 32'h0);
    chk("mid_rst_hrdata", hrdata, 32'h0);
    rst_n = 1'b1;
    ahb_read(32'h0, 32'h0, "mid_rst_ctrl");
    ahb_read(32'h4, 32'h0000_0C34, "mid_rst_div");
    ahb_read(32'h8, 32'h0, "mid_rst_data");
    ahb_read(32'hC, 32'h0, "mid_rst_stat");
    repeat (20) @(posedge hclk);
    #1 chk("mid_rst_no_int", {31'h0, int_o}, 32'h0);
    ahb_read(32'hC, 32'h0, "mid_rst_no_sample");

    repeat (3) @(posedge hclk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
